// File: rtl/int_vector_responder_if.sv
// Interrupt-vector memory port: emem_* request channel plus dp_* read data phase.
interface int_vector_responder_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int SIZEW = 8
);
  logic             emem_valid;
  logic             emem_ready;
  logic [ADDRW-1:0] emem_address;
  logic             emem_wr_en;
  logic [DATAW-1:0] emem_wr_data;
  logic [SIZEW-1:0] emem_wr_size;
  logic             emem_dp_valid;
  logic             emem_dp_ready;
  logic [DATAW-1:0] emem_dp_read_data;

  modport master (
    output emem_valid, emem_address, emem_wr_en, emem_wr_data, emem_wr_size, emem_dp_ready,
    input  emem_ready, emem_dp_valid, emem_dp_read_data
  );

  modport slave (
    input  emem_valid, emem_address, emem_wr_en, emem_wr_data, emem_wr_size, emem_dp_ready,
    output emem_ready, emem_dp_valid, emem_dp_read_data
  );
endinterface

// File: rtl/int_vector_responder.sv
// Interrupt-vector table responder: answers emem reads after LATENCY cycles.
// Define INT_VECTOR_WRITE_EN to make the table writable with byte/halfword/word lanes.
module int_vector_responder #(
  parameter int              ADDRW          = 32,
  parameter int              DATAW          = 32,
  parameter int              SIZEW          = 8,
  parameter int              ENTRIES        = 16,
  parameter int              LATENCY        = 2,
  parameter logic [31:0]     VEC_BASE       = 32'h0000_0400,
  parameter logic [31:0]     VEC_STRIDE     = 32'h0000_0040,
  parameter logic [DATAW-1:0] DEFAULT_VECTOR = 32'h0000_0040
) (
  input  logic                  clk,
  input  logic                  reset,
  int_vector_responder_if.slave emem
);
  localparam int IDXW = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [DATAW-1:0]  r_data;
  logic [IDXW-1:0]   w_idx;
  logic              w_in_range;
  logic              w_acc;
  logic              w_rd_acc;
  logic [DATAW-1:0]  w_entry;

  function automatic logic [DATAW-1:0] f_init(input int i);
    return DATAW'(VEC_BASE + VEC_STRIDE * 32'(i));
  endfunction

  assign w_idx      = emem.emem_address[IDXW+1:2];
  assign w_in_range = (emem.emem_address[ADDRW-1:IDXW+2] == '0);
  assign w_acc      = (r_state == S_IDLE) && emem.emem_valid;
  assign w_rd_acc   = w_acc && !emem.emem_wr_en;

`ifdef INT_VECTOR_WRITE_EN
  logic [ENTRIES-1:0][DATAW-1:0] r_table;
  logic [DATAW/8-1:0]            w_be;

  // Unsupported sizes leave every lane disabled, so the write is silently dropped.
  always_comb begin
    w_be = '0;
    case (emem.emem_wr_size)
      SIZEW'(1): w_be[emem.emem_address[1:0]] = 1'b1;
      SIZEW'(2): w_be[{emem.emem_address[1], 1'b0} +: 2] = 2'b11;
      SIZEW'(4): w_be = '1;
      default:   w_be = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= f_init(i);
    end else if (w_acc && emem.emem_wr_en && w_in_range) begin
      for (int b = 0; b < DATAW/8; b++)
        if (w_be[b]) r_table[w_idx][b*8 +: 8] <= emem.emem_wr_data[b*8 +: 8];
    end
  end

  assign w_entry = r_table[w_idx];
`else
  // Read-only table: write-side inputs are accepted and ignored.
  logic w_unused;
  assign w_unused = ^{emem.emem_wr_data, emem.emem_wr_size, emem.emem_address[1:0]};
  assign w_entry  = f_init(int'(w_idx));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rd_acc) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  if (emem.emem_dp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read data is latched at acceptance so the response cannot change while in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_acc) begin
        r_cnt  <= 4'(LATENCY - 1);
        r_data <= w_in_range ? w_entry : DEFAULT_VECTOR;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign emem.emem_ready        = (r_state == S_IDLE);
  assign emem.emem_dp_valid     = (r_state == S_RESP);
  assign emem.emem_dp_read_data = r_data;
endmodule

// File: tb/tb_int_vector_responder.sv
// Bench for int_vector_responder: LATENCY=2 instance for the main tests, LATENCY=1 for throughput.
module tb_int_vector_responder;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

`ifdef INT_VECTOR_WRITE_EN
  localparam logic [31:0] EXP_W1 = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_W2 = 32'hDEAD_AAEF;
  localparam logic [31:0] EXP_W3 = 32'h1234_AAEF;
`else
  localparam logic [31:0] EXP_W1 = 32'h0000_0480;
  localparam logic [31:0] EXP_W2 = 32'h0000_0480;
  localparam logic [31:0] EXP_W3 = 32'h0000_0480;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_vector_responder_if #(.ADDRW(32), .DATAW(32), .SIZEW(8)) if0 ();
  int_vector_responder_if #(.ADDRW(32), .DATAW(32), .SIZEW(8)) if1 ();

  int_vector_responder #(.LATENCY(LAT0)) u_dut0 (.clk(clk), .reset(rst_n), .emem(if0));
  int_vector_responder #(.LATENCY(LAT1)) u_dut1 (.clk(clk), .reset(rst_n), .emem(if1));

  // Called at a negedge, returns at a negedge with the DUT back in IDLE.
  task automatic rd0(input logic [31:0] addr, input int hold, input bit early, input logic [31:0] exp);
    int k;
    logic [31:0] d, e;
    exp_q.push_back(exp);
    checks++;
    if (if0.emem_ready !== 1'b1 || if0.emem_dp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle addr=%h ready=%b dp_valid=%b want 1/0", addr, if0.emem_ready, if0.emem_dp_valid);
    end
    if0.emem_valid = 1'b1; if0.emem_wr_en = 1'b0; if0.emem_address = addr;
    if0.emem_dp_ready = early;
    @(posedge clk);
    @(negedge clk);
    if0.emem_valid = 1'b0;
    k = 0;
    while (!if0.emem_dp_valid && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k !== LAT0) begin
      errors++;
      $display("FAIL rd_latency addr=%h got %0d want %0d", addr, k, LAT0);
    end
    d = if0.emem_dp_read_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (if0.emem_dp_valid !== 1'b1 || if0.emem_ready !== 1'b0 || if0.emem_dp_read_data !== d) begin
        errors++;
        $display("FAIL rd_hold addr=%h cyc%0d dp_valid=%b ready=%b data=%h want 1/0/%h",
                 addr, i, if0.emem_dp_valid, if0.emem_ready, if0.emem_dp_read_data, d);
      end
    end
    if0.emem_dp_ready = 1'b1;
    @(negedge clk);
    if0.emem_dp_ready = 1'b0;
    checks++;
    if (if0.emem_dp_valid !== 1'b0 || if0.emem_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_release addr=%h dp_valid=%b ready=%b want 0/1", addr, if0.emem_dp_valid, if0.emem_ready);
    end
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rd_data addr=%h got %h want %h", addr, d, e);
    end
  endtask

  // Leaves valid asserted so a following rd0 is accepted on the very next edge.
  task automatic wr0(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] size);
    checks++;
    if (if0.emem_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready addr=%h got %b want 1", addr, if0.emem_ready);
    end
    if0.emem_valid = 1'b1; if0.emem_wr_en = 1'b1; if0.emem_address = addr;
    if0.emem_wr_data = data; if0.emem_wr_size = size;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (if0.emem_ready !== 1'b1 || if0.emem_dp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_nodata addr=%h ready=%b dp_valid=%b want 1/0", addr, if0.emem_ready, if0.emem_dp_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (if0.emem_ready !== 1'b1 || if0.emem_dp_valid !== 1'b0 || if0.emem_dp_read_data !== 32'h0 ||
        if1.emem_ready !== 1'b1 || if1.emem_dp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b dp_valid=%b data=%h ready1=%b want 1/0/0/1",
               if0.emem_ready, if0.emem_dp_valid, if0.emem_dp_read_data, if1.emem_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    rd0(32'h0000_0000, 0, 1'b1, 32'h0000_0400);
    rd0(32'h0000_000C, 5, 1'b0, 32'h0000_04C0);
    rd0(32'h0000_003F, 0, 1'b0, 32'h0000_07C0);
    rd0(32'h0000_0100, 0, 1'b0, 32'h0000_0040);
    rd0(32'h0000_0040, 0, 1'b0, 32'h0000_0040);
    rd0(32'h8000_0008, 0, 1'b0, 32'h0000_0040);
  endtask

  task automatic test_write();
    wr0(32'h0000_0008, 32'hDEAD_BEEF, 8'd4);
    rd0(32'h0000_0008, 0, 1'b0, EXP_W1);
    wr0(32'h0000_0009, 32'hAAAA_AAAA, 8'd1);
    rd0(32'h0000_0008, 0, 1'b0, EXP_W2);
    wr0(32'h0000_000A, 32'h1234_5678, 8'd2);
    wr0(32'h0000_0008, 32'hFFFF_FFFF, 8'd3);
    wr0(32'h0000_0048, 32'h5555_5555, 8'd4);
    rd0(32'h0000_0008, 0, 1'b0, EXP_W3);
    rd0(32'h0000_000C, 0, 1'b0, 32'h0000_04C0);
  endtask

  task automatic test_back_to_back();
    for (int i = 4; i < 7; i++) rd0(32'(i * 4), 0, 1'b1, 32'h400 + 32'(i) * 32'h40);
  endtask

  task automatic test_reset_midflight();
    if0.emem_valid = 1'b1; if0.emem_wr_en = 1'b0; if0.emem_address = 32'h8;
    @(posedge clk);
    @(negedge clk);
    if0.emem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.emem_ready !== 1'b1 || if0.emem_dp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait ready=%b dp_valid=%b want 1/0", if0.emem_ready, if0.emem_dp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if0.emem_valid = 1'b1; if0.emem_address = 32'hC;
    @(posedge clk);
    @(negedge clk);
    if0.emem_valid = 1'b0;
    repeat (LAT0) @(negedge clk);
    checks++;
    if (if0.emem_dp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_resp dp_valid=%b want 1", if0.emem_dp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.emem_dp_valid !== 1'b0 || if0.emem_ready !== 1'b1 || if0.emem_dp_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp dp_valid=%b ready=%b data=%h want 0/1/0",
               if0.emem_dp_valid, if0.emem_ready, if0.emem_dp_read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd0(32'h0000_0008, 0, 1'b0, 32'h0000_0480);
  endtask

  task automatic test_latency1();
    int acc, n, lat;
    bit seen;
    logic [31:0] d, e;
    if1.emem_dp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h400 + 32'(i) * 32'h40);
      checks++;
      if (if1.emem_ready !== 1'b1) begin
        errors++;
        $display("FAIL l1_ready i=%0d got %b want 1", i, if1.emem_ready);
      end
      if1.emem_valid = 1'b1; if1.emem_wr_en = 1'b0; if1.emem_address = 32'(i * 4);
      @(posedge clk);
      @(negedge clk);
      if1.emem_valid = 1'b0;
      acc = cyc; n = 0; seen = 1'b0; lat = -1; d = '0;
      while (!if1.emem_ready && n < 20) begin
        if (if1.emem_dp_valid && !seen) begin seen = 1'b1; lat = cyc - acc; d = if1.emem_dp_read_data; end
        @(negedge clk);
        n++;
      end
      checks++;
      if (lat !== LAT1 || (cyc - acc) !== 2) begin
        errors++;
        $display("FAIL l1_timing i=%0d latency=%0d total=%0d want %0d/2", i, lat, cyc - acc, LAT1);
      end
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL l1_data i=%0d got %h want %h", i, d, e);
      end
    end
    if1.emem_dp_ready = 1'b0;
  endtask

  initial begin
    if0.emem_valid = 1'b0; if0.emem_address = '0; if0.emem_wr_en = 1'b0;
    if0.emem_wr_data = '0; if0.emem_wr_size = '0; if0.emem_dp_ready = 1'b0;
    if1.emem_valid = 1'b0; if1.emem_address = '0; if1.emem_wr_en = 1'b0;
    if1.emem_wr_data = '0; if1.emem_wr_size = '0; if1.emem_dp_ready = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_midflight();
    test_latency1();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
